ca_prng_multi: RTL and testbench
================================

// Module: ca_prng_multi
// PURPOSE
//  Multi-channel cellular-automaton PRNG: NUM_CH elementary-CA grids step in lockstep, each with its own rule
//  and seed, both reloadable at run time. Each grid feeds one N-bit word builder. Words leave through a
//  valid/ready port, either XOR-combined or round-robin per channel. Generalised successor of the fixed three-rule array.
// PARAMETERS
//  ARRAY_WIDTH  51                        cells per CA grid
//  NUM_CH       3                         number of CA channels (>=1)
//  N            10                        random word width
//  LOCATION     ARRAY_WIDTH/2             cell index sampled into the word builder
//  SEED_INIT    {25'd0,1'b1,25'd0}        grid value after reset
//  RULES_INIT   {8'd150,8'd60,8'd30}      NUM_CH*8 bits, rule of ch k = RULES_INIT[8k+:8]
// PORTS
//  i_clk        in   1                    clock, all state on posedge
//  i_rst        in   1                    asynchronous, active-low reset
//  i_en         in   1                    1 = run the generator
//  i_mode       in   1                    0 = XOR of all channel words, 1 = round-robin per channel
//  i_cfg_valid  in   1                    config request
//  o_cfg_ready  out  1                    config accepted when valid&ready
//  i_cfg_ch     in   $clog2(NUM_CH)       channel to reconfigure (>=NUM_CH ignored, still handshaken)
//  i_cfg_rule   in   8                    new Wolfram rule
//  i_cfg_seed   in   ARRAY_WIDTH          new grid contents
//  o_rn_valid   out  1                    word available
//  i_rn_ready   in   1                    consumer takes word when valid&ready
//  o_rn         out  N                    random word
//  o_rn_ch      out  $clog2(NUM_CH)       source channel (0 in XOR mode)
// BEHAVIOUR
//  - Reset (i_rst=0): grids=SEED_INIT, rules=RULES_INIT, word regs=0, bit counter=0.
//    Reset also clears o_rn=0, o_rn_ch=0, o_rn_valid=0, and o_cfg_ready=0. State is S_IDLE.
//  - CA step: cell i has left=i+1 and right=i-1, with cyclic wrap (cell ARRAY_WIDTH-1's left is cell 0).
//    next[i] = rule[{left,cell,right}].
//  - Each step, every word reg shifts left and takes grid[LOCATION] (pre-update value) into its LSB.
//    The first sampled bit therefore ends as the MSB.
//  - FSM:
//    - S_IDLE: no stepping. Goes to S_FILL when i_en=1; i_mode is latched on this transition.
//    - S_FILL: one step per cycle while i_en=1; i_en=0 freezes all state.
//      After the N-th step: latch the output word(s) and the channel index, then go to S_OUT.
//    - S_OUT: o_rn_valid=1 and grids do not step (backpressure).
//      XOR mode: one handshake returns to S_FILL (or to S_IDLE if i_en=0).
//      RR mode: the channel index runs 0..NUM_CH-1, one handshake each; after the last one, leave as in XOR mode.
//  - Latency: N cycles from entering S_FILL to o_rn_valid, with i_en held at 1.
//  - o_rn/o_rn_ch are stable while o_rn_valid=1 && !i_rn_ready. Valid is never dropped without a handshake.
//  - o_cfg_ready=1 in S_IDLE and S_FILL only.
//    On acceptance: the channel grid gets i_cfg_seed and the channel rule gets i_cfg_rule.
//    Also on acceptance: all word regs and the bit counter clear, the partial word is discarded, and no step happens that cycle.
//  - Config accepted in the same cycle as a would-be N-th step: config wins and no word is produced.
//  - An all-zero seed is accepted as-is (rule decides evolution; no guard).
//  - Reset asserted mid-word or mid-output: immediate return to reset state; any pending word is lost.
// TESTING
//  1. Defaults: release reset with i_en=1, i_mode=1, ready=1.
//     -> ch0 (rule 30) o_rn=10'h373, then ch1 (rule 60) o_rn=10'h3FF, valid first at cycle 10.
//  2. NUM_CH=2, RULES_INIT={60,30}, i_mode=0.
//     -> first o_rn=10'h08C (0x373^0x3FF), o_rn_ch=0.
//  3. Hold i_rn_ready=0 for 20 cycles after valid.
//     -> o_rn stable, grids unchanged; after ready, the next word arrives 10 cycles later and matches the free-run value.
//  4. Mid-fill (step 5), cfg ch0 rule 60 with seed SEED_INIT.
//     -> partial word discarded, ch0 next word 10'h3FF; cfg during S_OUT gets o_cfg_ready=0.
//  5. i_en toggles 0/1 every cycle.
//     -> words identical to test 1, valid at cycle 20.
//  6. Assert i_rst while o_rn_valid=1.
//     -> o_rn_valid=0 asynchronously; after release, test-1 sequence repeats exactly.

Source files
------------

// File: rtl/ca_prng_multi.sv
// Multi-channel elementary cellular-automaton PRNG. NUM_CH grids step in lockstep and each feeds an N-bit
// word builder; finished words leave on a valid/ready port, either XOR-combined or one channel at a time.
module ca_prng_multi #(
  parameter int ARRAY_WIDTH = 51,
  parameter int NUM_CH = 3,
  parameter int N = 10,
  parameter int LOCATION = ARRAY_WIDTH / 2,
  parameter logic [ARRAY_WIDTH-1:0] SEED_INIT = {25'd0, 1'b1, 25'd0},
  parameter logic [NUM_CH*8-1:0] RULES_INIT = {8'd150, 8'd60, 8'd30},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_mode,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [CH_W-1:0]        i_cfg_ch,
  input  logic [7:0]             i_cfg_rule,
  input  logic [ARRAY_WIDTH-1:0] i_cfg_seed,
  output logic                   o_rn_valid,
  input  logic                   i_rn_ready,
  output logic [N-1:0]           o_rn,
  output logic [CH_W-1:0]        o_rn_ch
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OUT} state_t;
  state_t state, state_nx;

  logic [ARRAY_WIDTH-1:0] grid     [NUM_CH];
  logic [7:0]             rule     [NUM_CH];
  logic [N-1:0]           word     [NUM_CH];
  logic [N-1:0]           word_nx  [NUM_CH];
  logic [N-1:0]           word_lat [NUM_CH];
  logic [N-1:0]           word_xor;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   mode;
  logic [CH_W-1:0]        ch, ch_inc;
  logic                   cfg_fire, rn_fire, step, last_step, last_ch;

  // Left neighbour is the next-higher cell, right is the next-lower, both wrapping around the ring.
  function automatic logic [ARRAY_WIDTH-1:0] ca_step(input logic [ARRAY_WIDTH-1:0] g,
                                                      input logic [7:0] r);
    logic [ARRAY_WIDTH-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < ARRAY_WIDTH; i++) begin
      nxt[i] = r[{g[(i + 1) % ARRAY_WIDTH], g[i], g[(i + ARRAY_WIDTH - 1) % ARRAY_WIDTH]}];
    end
    return nxt;
  endfunction

  always_comb begin
    cfg_fire  = i_cfg_valid && o_cfg_ready;
    rn_fire   = o_rn_valid && i_rn_ready;
    step      = (state == S_FILL) && i_en && !cfg_fire;
    last_step = step && (bit_cnt == CNT_W'(N - 1));
    last_ch   = !mode || (ch == CH_W'(NUM_CH - 1));
    ch_inc    = ch + CH_W'(1);
  end

  always_comb begin
    word_xor = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      word_nx[k] = {word[k][N-2:0], grid[k][LOCATION]};
      word_xor   = word_xor ^ word_nx[k];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_en) state_nx = S_FILL;
      S_FILL:  if (last_step) state_nx = S_OUT;
      S_OUT:   if (rn_fire && last_ch) state_nx = i_en ? S_FILL : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Config takes priority over stepping, so a request landing on the last step discards that word.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= S_IDLE;
      mode        <= 1'b0;
      ch          <= '0;
      bit_cnt     <= '0;
      o_rn        <= '0;
      o_rn_ch     <= '0;
      o_rn_valid  <= 1'b0;
      o_cfg_ready <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        grid[k]     <= SEED_INIT;
        rule[k]     <= RULES_INIT[8*k +: 8];
        word[k]     <= '0;
        word_lat[k] <= '0;
      end
    end else begin
      state       <= state_nx;
      o_rn_valid  <= (state_nx == S_OUT);
      o_cfg_ready <= (state_nx != S_OUT);
      if (state == S_IDLE && i_en) mode <= i_mode;

      if (cfg_fire) begin
        bit_cnt <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          word[k] <= '0;
          if (i_cfg_ch == CH_W'(k)) begin
            grid[k] <= i_cfg_seed;
            rule[k] <= i_cfg_rule;
          end
        end
      end else if (step) begin
        bit_cnt <= last_step ? '0 : bit_cnt + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          grid[k] <= ca_step(grid[k], rule[k]);
          word[k] <= word_nx[k];
        end
        if (last_step) begin
          for (int k = 0; k < NUM_CH; k++) word_lat[k] <= word_nx[k];
          o_rn    <= mode ? word_nx[0] : word_xor;
          o_rn_ch <= '0;
          ch      <= '0;
        end
      end

      // Round-robin: each handshake except the last presents the next channel's latched word.
      if (state == S_OUT && rn_fire && !last_ch) begin
        ch      <= ch_inc;
        o_rn    <= word_lat[ch_inc];
        o_rn_ch <= ch_inc;
      end
    end
  end

endmodule

// File: tb/tb_ca_prng_multi.sv
// Directed bench for ca_prng_multi: a 3-channel round-robin instance and a 2-channel XOR instance
// share clock, reset and control; expected words are hand-derived CA centre columns.
module tb_ca_prng_multi;

  localparam logic [50:0] SEED = {25'd0, 1'b1, 25'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode, cfg_valid, rn_ready;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_rule;
  logic [50:0] cfg_seed;
  logic        cfg_ready, rn_valid;
  logic [9:0]  rn;
  logic [1:0]  rn_ch;
  logic        mode2;
  logic        cfg_ready2, rn_valid2;
  logic [9:0]  rn2;
  logic [0:0]  rn_ch2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ca_prng_multi dut (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_mode(mode),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch),
    .i_cfg_rule(cfg_rule), .i_cfg_seed(cfg_seed),
    .o_rn_valid(rn_valid), .i_rn_ready(rn_ready), .o_rn(rn), .o_rn_ch(rn_ch)
  );

  ca_prng_multi #(.NUM_CH(2), .RULES_INIT({8'd60, 8'd30})) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_mode(mode2),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready2), .i_cfg_ch(cfg_ch[0:0]),
    .i_cfg_rule(cfg_rule), .i_cfg_seed(cfg_seed),
    .o_rn_valid(rn_valid2), .i_rn_ready(rn_ready), .o_rn(rn2), .o_rn_ch(rn_ch2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; mode2 = 1'b0; rn_ready = 1'b1;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_rule = 8'd0; cfg_seed = '0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(rn_valid), 64'd0);
    check("rst_rn", 64'(rn), 64'd0);
    check("rst_rn_ch", 64'(rn_ch), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_valid2", 64'(rn_valid2), 64'd0);
    rst_n = 1'b1;

    // Test 1/2: free run, round-robin on dut, XOR on dut2
    repeat (10) tick();
    check("t1_valid_early", 64'(rn_valid), 64'd0);
    check("t1_cfg_ready_fill", 64'(cfg_ready), 64'd1);
    tick();
    check("t1_valid", 64'(rn_valid), 64'd1);
    check("t1_rn_ch0", 64'(rn), 64'h373);
    check("t1_ch0", 64'(rn_ch), 64'd0);
    check("t2_valid", 64'(rn_valid2), 64'd1);
    check("t2_rn_xor", 64'(rn2), 64'h08C);
    check("t2_ch", 64'(rn_ch2), 64'd0);
    tick();
    check("t1_rn_ch1", 64'(rn), 64'h3FF);
    check("t1_ch1", 64'(rn_ch), 64'd1);
    tick();
    check("t1_rn_ch2", 64'(rn), 64'h3FF);
    check("t1_ch2", 64'(rn_ch), 64'd2);
    tick();
    check("t1_out_exit", 64'(rn_valid), 64'd0);
    repeat (9) tick();
    check("t1_w2_early", 64'(rn_valid), 64'd0);
    tick();
    check("t1_w2_valid", 64'(rn_valid), 64'd1);
    check("t1_w2_rn", 64'(rn), 64'h059);
    check("t1_w2_ch", 64'(rn_ch), 64'd0);

    // Test 3: backpressure
    rn_ready = 1'b0;
    do_reset();
    repeat (11) tick();
    check("t3_valid", 64'(rn_valid), 64'd1);
    repeat (20) tick();
    check("t3_hold_valid", 64'(rn_valid), 64'd1);
    check("t3_hold_rn", 64'(rn), 64'h373);
    check("t3_hold_ch", 64'(rn_ch), 64'd0);
    check("t3_cfg_ready_out", 64'(cfg_ready), 64'd0);
    rn_ready = 1'b1;
    tick();
    check("t3_rn_ch1", 64'(rn), 64'h3FF);
    tick();
    tick();
    repeat (9) tick();
    check("t3_w2_early", 64'(rn_valid), 64'd0);
    tick();
    check("t3_w2_valid", 64'(rn_valid), 64'd1);
    check("t3_w2_rn", 64'(rn), 64'h059);

    // Test 4: reconfigure mid-fill, then attempt during S_OUT
    rn_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_rule = 8'd60; cfg_seed = SEED;
    check("t4_cfg_ready_fill", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    repeat (9) tick();
    check("t4_discard", 64'(rn_valid), 64'd0);
    tick();
    check("t4_valid", 64'(rn_valid), 64'd1);
    check("t4_rn_ch0", 64'(rn), 64'h3FF);
    check("t4_ch0", 64'(rn_ch), 64'd0);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_rule = 8'd30; cfg_seed = SEED;
    check("t4_cfg_ready_out", 64'(cfg_ready), 64'd0);
    tick();
    cfg_valid = 1'b0;
    check("t4_out_hold", 64'(rn), 64'h3FF);
    rn_ready = 1'b1;
    tick();
    check("t4_rn_ch1", 64'(rn), 64'h3FF);
    check("t4_ch1", 64'(rn_ch), 64'd1);
    tick();
    tick();
    rn_ready = 1'b0;
    repeat (9) tick();
    check("t4_w2_early", 64'(rn_valid), 64'd0);
    tick();
    check("t4_w2_valid", 64'(rn_valid), 64'd1);
    check("t4_w2_rn", 64'(rn), 64'h3FF);

    // Test 5: enable toggling every cycle
    en = 1'b1;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 20) check("t5_valid_early", 64'(rn_valid), 64'd0);
      en = (k % 2 == 0);
    end
    check("t5_valid", 64'(rn_valid), 64'd1);
    check("t5_rn_ch0", 64'(rn), 64'h373);
    rn_ready = 1'b1;
    tick();
    check("t5_rn_ch1", 64'(rn), 64'h3FF);
    check("t5_ch1", 64'(rn_ch), 64'd1);
    rn_ready = 1'b0;
    en = 1'b1;

    // Test 6: reset while a word is pending
    do_reset();
    repeat (11) tick();
    check("t6_valid_before", 64'(rn_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(rn_valid), 64'd0);
    check("t6_async_rn", 64'(rn), 64'd0);
    tick();
    rst_n = 1'b1;
    rn_ready = 1'b1;
    repeat (10) tick();
    check("t6_valid_early", 64'(rn_valid), 64'd0);
    tick();
    check("t6_rn_ch0", 64'(rn), 64'h373);
    check("t6_ch0", 64'(rn_ch), 64'd0);
    tick();
    check("t6_rn_ch1", 64'(rn), 64'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
